// File: rtl/gcd_pkg.sv
// Shared types and defaults for the iterative GCD engine.
package gcd_pkg;

  localparam int unsigned GCD_WIDTH_DEF = 16;
  localparam int unsigned GCD_CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } gcd_state_t;

endpackage

// File: rtl/gcd_step.sv
// One combinational GCD iteration: Euclid subtraction by default,
// binary (Stein) step with power-of-two exponent k when GCD_STEIN_EN is defined.
module gcd_step #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned K_W   = $clog2(WIDTH) + 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef GCD_STEIN_EN
  input  logic [K_W-1:0]   k,
  output logic [K_W-1:0]   k_nxt_c,
`endif
  output logic [WIDTH-1:0] a_nxt_c,
  output logic [WIDTH-1:0] b_nxt_c,
  output logic             done_c,
  output logic [WIDTH-1:0] result_c
);

`ifdef GCD_STEIN_EN
  always_comb begin
    a_nxt_c  = a;
    b_nxt_c  = b;
    k_nxt_c  = k;
    done_c   = 1'b0;
    result_c = '0;
    if (a == '0) begin
      done_c   = 1'b1;
      result_c = WIDTH'(b << k);
    end else if (b == '0) begin
      done_c   = 1'b1;
      result_c = WIDTH'(a << k);
    end else if (!a[0] && !b[0]) begin
      a_nxt_c = a >> 1;
      b_nxt_c = b >> 1;
      k_nxt_c = k + K_W'(1);
    end else if (!a[0]) begin
      a_nxt_c = a >> 1;
    end else if (!b[0]) begin
      b_nxt_c = b >> 1;
    end else if (a >= b) begin
      // Difference of two odd values is even, so the shift is exact.
      a_nxt_c = WIDTH'(a - b) >> 1;
    end else begin
      b_nxt_c = WIDTH'(b - a) >> 1;
    end
  end
`else
  always_comb begin
    a_nxt_c  = a;
    b_nxt_c  = b;
    done_c   = 1'b0;
    result_c = a;
    if (b == '0) begin
      done_c = 1'b1;
    end else if (a < b) begin
      a_nxt_c = b;
      b_nxt_c = a;
    end else begin
      a_nxt_c = WIDTH'(a - b);
    end
  end
`endif

endmodule

// File: rtl/gcd_unit.sv
// Iterative GCD engine with valid/ready on both sides and saturating cycle count.
// Define GCD_STEIN_EN to select the binary (Stein) iteration instead of Euclid subtraction.
module gcd_unit
  import gcd_pkg::*;
#(
  parameter int unsigned WIDTH = GCD_WIDTH_DEF,
  parameter int unsigned CNT_W = GCD_CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [2*WIDTH-1:0] in_data,
  output logic               in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [CNT_W-1:0]   out_cycles,
  input  logic               out_ready
);

  localparam int unsigned K_W = $clog2(WIDTH) + 1;

  gcd_state_t       state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_inc_c;
  logic [WIDTH-1:0] a_nxt_c, b_nxt_c, result_c;
  logic             done_c;
`ifdef GCD_STEIN_EN
  logic [K_W-1:0]   k_q, k_nxt_c;
`endif

  assign in_ready    = (state_q == S_IDLE) && !rst;
  assign count_inc_c = (&count_q) ? count_q : count_q + CNT_W'(1);

  gcd_step #(
    .WIDTH (WIDTH),
    .K_W   (K_W)
  ) u_step (
    .a        (a_q),
    .b        (b_q),
`ifdef GCD_STEIN_EN
    .k        (k_q),
    .k_nxt_c  (k_nxt_c),
`endif
    .a_nxt_c  (a_nxt_c),
    .b_nxt_c  (b_nxt_c),
    .done_c   (done_c),
    .result_c (result_c)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid) state_d = S_CALC;
      S_CALC:  if (done_c)   state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Operand, counter and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q        <= '0;
      b_q        <= '0;
      count_q    <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_cycles <= '0;
`ifdef GCD_STEIN_EN
      k_q        <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            a_q     <= in_data[2*WIDTH-1:WIDTH];
            b_q     <= in_data[WIDTH-1:0];
            count_q <= '0;
`ifdef GCD_STEIN_EN
            k_q     <= '0;
`endif
          end
        end
        S_CALC: begin
          count_q <= count_inc_c;
          a_q     <= a_nxt_c;
          b_q     <= b_nxt_c;
`ifdef GCD_STEIN_EN
          k_q     <= k_nxt_c;
`endif
          if (done_c) begin
            out_valid  <= 1'b1;
            out_data   <= result_c;
            out_cycles <= count_inc_c;
          end
        end
        S_DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: out_valid <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_unit.sv
// Directed self-checking bench for gcd_unit (Euclid default, Stein with GCD_STEIN_EN).
module tb_gcd_unit;

`ifdef GCD_STEIN_EN
  localparam bit STEIN = 1'b1;
`else
  localparam bit STEIN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic [15:0] out_cycles;
  logic        out_ready;

  int n_pass = 0;
  int n_total = 0;

  gcd_unit #(.WIDTH(16), .CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_cycles (out_cycles),
    .out_ready  (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic send(input logic [15:0] a, input logic [15:0] b, output bit ok);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    ok = in_ready;
    in_valid = 1'b1;
    in_data  = {a, b};
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input int budget, output int lat, output bit timeout);
    lat = 0;
    while (!out_valid && lat < budget) begin
      @(posedge clk);
      #1;
      lat++;
    end
    timeout = !out_valid;
  endtask

  task automatic accept();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %0b want 0", out_valid); else n_pass++;
    n_total++;
    if (out_data !== 16'd0) $display("FAIL reset_out_data got %0d want 0", out_data); else n_pass++;
    n_total++;
    if (out_cycles !== 16'd0) $display("FAIL reset_out_cycles got %0d want 0", out_cycles); else n_pass++;
    n_total++;
    if (in_ready !== 1'b0) $display("FAIL reset_in_ready_during got %0b want 0", in_ready); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready_after got %0b want 1", in_ready); else n_pass++;
  endtask

  task automatic test_basic();
    bit ok, to;
    int lat;
    logic [15:0] exp_cyc;
    exp_cyc = STEIN ? 16'd8 : 16'd6;
    send(16'h0030, 16'h0020, ok);
    wait_out(200, lat, to);
    n_total++;
    if (!ok || to) $display("FAIL basic_handshake ok=%0b timeout=%0b", ok, to); else n_pass++;
    n_total++;
    if (out_data !== 16'd16) $display("FAIL basic_data got %0d want 16", out_data); else n_pass++;
    n_total++;
    if (out_cycles !== exp_cyc) $display("FAIL basic_cycles got %0d want %0d", out_cycles, exp_cyc); else n_pass++;
    n_total++;
    if (lat !== int'(exp_cyc)) $display("FAIL basic_latency got %0d want %0d", lat, exp_cyc); else n_pass++;
    n_total++;
    if (in_ready !== 1'b0) $display("FAIL basic_in_ready_done got %0b want 0", in_ready); else n_pass++;
    accept();
    n_total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL basic_release got valid=%0b ready=%0b want 0/1", out_valid, in_ready);
    else n_pass++;
  endtask

  task automatic test_zeros();
    logic [15:0] za [3] = '{16'd0, 16'd7, 16'd0};
    logic [15:0] zb [3] = '{16'd0, 16'd0, 16'd7};
    logic [15:0] zr [3] = '{16'd0, 16'd7, 16'd7};
    logic [15:0] zc [3] = '{16'd1, 16'd1, 16'd2};
    bit ok, to;
    int lat;
    logic [15:0] exp_cyc;
    for (int i = 0; i < 3; i++) begin
      exp_cyc = STEIN ? 16'd1 : zc[i];
      send(za[i], zb[i], ok);
      wait_out(50, lat, to);
      n_total++;
      if (!ok || to || out_data !== zr[i])
        $display("FAIL zero_%0d_data got %0d want %0d (timeout=%0b)", i, out_data, zr[i], to);
      else n_pass++;
      n_total++;
      if (out_cycles !== exp_cyc || lat !== int'(exp_cyc))
        $display("FAIL zero_%0d_cycles got %0d lat %0d want %0d", i, out_cycles, lat, exp_cyc);
      else n_pass++;
      accept();
    end
  endtask

  task automatic test_backpressure();
    bit ok, to, seen;
    int lat;
    send(16'd48, 16'd32, ok);
    wait_out(200, lat, to);
    n_total++;
    if (!ok || to) $display("FAIL bp_handshake ok=%0b timeout=%0b", ok, to); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_total++;
      if (out_valid !== 1'b1 || out_data !== 16'd16 || in_ready !== 1'b0)
        $display("FAIL bp_hold_%0d got valid=%0b data=%0d ready=%0b want 1/16/0",
                 i, out_valid, out_data, in_ready);
      else n_pass++;
      in_valid = i[0] ? 1'b0 : 1'b1;
      in_data  = 32'h0009_0006;
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    n_total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL bp_release got valid=%0b ready=%0b want 0/1", out_valid, in_ready);
    else n_pass++;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    n_total++;
    if (seen !== 1'b0) $display("FAIL bp_ignored_input got spurious out_valid=%0b want 0", seen); else n_pass++;
  endtask

  task automatic test_reset_mid_calc();
    bit ok, to, seen;
    int lat;
    logic [15:0] exp_cyc;
    exp_cyc = STEIN ? 16'd4 : 16'd6;
    send(16'd48, 16'd32, ok);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    n_total++;
    if (!ok || in_ready !== 1'b1) $display("FAIL rstmid_in_ready got %0b want 1", in_ready); else n_pass++;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    n_total++;
    if (seen !== 1'b0) $display("FAIL rstmid_no_output got out_valid=%0b want 0", seen); else n_pass++;
    send(16'd21, 16'd14, ok);
    wait_out(200, lat, to);
    n_total++;
    if (!ok || to || out_data !== 16'd7)
      $display("FAIL rstmid_next_data got %0d want 7 (timeout=%0b)", out_data, to);
    else n_pass++;
    n_total++;
    if (out_cycles !== exp_cyc) $display("FAIL rstmid_next_cycles got %0d want %0d", out_cycles, exp_cyc); else n_pass++;
    accept();
  endtask

  task automatic test_saturation();
    bit ok, to;
    int lat;
    logic [15:0] exp_cyc;
    int exp_lat;
    exp_cyc = STEIN ? 16'd17 : 16'hFFFF;
    exp_lat = STEIN ? 17 : 65537;
    send(16'hFFFF, 16'h0001, ok);
    wait_out(70000, lat, to);
    n_total++;
    if (!ok || to || out_data !== 16'd1)
      $display("FAIL sat_data got %0d want 1 (timeout=%0b)", out_data, to);
    else n_pass++;
    n_total++;
    if (out_cycles !== exp_cyc) $display("FAIL sat_cycles got %0h want %0h", out_cycles, exp_cyc); else n_pass++;
    n_total++;
    if (lat !== exp_lat) $display("FAIL sat_latency got %0d want %0d", lat, exp_lat); else n_pass++;
    accept();
  endtask

  task automatic test_back_to_back();
    logic [15:0] pa [8] = '{16'd12, 16'd100, 16'd17, 16'd64, 16'h55, 16'd9, 16'd0, 16'd1000};
    logic [15:0] pb [8] = '{16'd18, 16'd75,  16'd5,  16'd48, 16'h11, 16'd0, 16'd13, 16'd250};
    logic [15:0] pr [8] = '{16'd6,  16'd25,  16'd1,  16'd16, 16'h11, 16'd9, 16'd13, 16'd250};
    fork
      begin
        bit ok;
        for (int i = 0; i < 8; i++) begin
          send(pa[i], pb[i], ok);
          if (!ok) begin
            n_total++;
            $display("FAIL b2b_send_%0d in_ready never rose", i);
          end
        end
      end
      begin
        int got = 0;
        int cyc = 0;
        logic r;
        while (got < 8 && cyc < 5000) begin
          @(negedge clk);
          cyc++;
          r = 1'($urandom_range(0, 1));
          out_ready = r;
          if (out_valid && r) begin
            n_total++;
            if (out_data !== pr[got])
              $display("FAIL b2b_result_%0d got %0d want %0d", got, out_data, pr[got]);
            else n_pass++;
            got++;
          end
        end
        @(negedge clk);
        out_ready = 1'b0;
        n_total++;
        if (got !== 8) $display("FAIL b2b_count got %0d want 8", got); else n_pass++;
      end
    join
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zeros();
    test_backpressure();
    test_reset_mid_calc();
    test_saturation();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
